// File: rtl/mvau_out_stream.sv
// +----------------------------------------------------------------------------+
// | mvau_out_stream: buffers MVAU result words and re-emits them as a narrower |
// | ready/valid stream with a per-vector last marker.                          |
// | Optional beat/vector counters: define MVAU_OUT_STREAM_CNT_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mvau_out_stream #(
  parameter int PE           = 2,
  parameter int TDstI        = 16,
  parameter int OUT_LANES    = 1,
  parameter int MatrixH      = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_v,
  input  logic [PE*TDstI-1:0]           in,
  output logic                          afull,
  output logic                          out_v,
  input  logic                          out_rdy,
  output logic [OUT_LANES*TDstI-1:0]    out,
  output logic                          out_last,
  output logic                          ovf,
  output logic [$clog2(DEPTH+1)-1:0]    level
`ifdef MVAU_OUT_STREAM_CNT_EN
  ,
  output logic [31:0]                   beat_cnt,
  output logic [31:0]                   vec_cnt
`endif
);

  localparam int NG  = PE / OUT_LANES;
  localparam int GW  = OUT_LANES * TDstI;
  localparam int WW  = PE * TDstI;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int LNW = (NG > 1) ? $clog2(NG) : 1;
  localparam int EW  = (MatrixH > 1) ? $clog2(MatrixH) : 1;

  localparam logic [LW-1:0]  DEPTH_L   = LW'(DEPTH);
  localparam logic [LNW-1:0] LAST_GRP  = LNW'(NG - 1);
  localparam logic [EW-1:0]  LAST_ELEM = EW'(MatrixH - OUT_LANES);
  localparam logic [EW-1:0]  EL_STEP   = EW'(OUT_LANES);

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   hold_q, hold_d;
  logic [LNW-1:0]  lane_q, lane_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [GW-1:0]   out_q, out_d;
  logic            out_last_q, out_last_d;
  logic            afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WW-1:0]   mem_q [DEPTH];

  logic            accept;
  logic            last_grp;
  logic            pop;
  logic            wr;
  logic [31:0]     free_slots;
  int              shamt;

  always_comb begin
    accept   = (state_q == SEND) && out_rdy;
    last_grp = (lane_q == LAST_GRP);
    // The hold register pulls the next word either when idle or as the last
    // lane group of the current word leaves, so back-to-back words never bubble.
    pop      = (level_q != '0) && ((state_q == EMPTY) || (accept && last_grp));
    wr       = in_v && ((level_q != DEPTH_L) || pop);

    state_d    = state_q;
    hold_d     = hold_q;
    lane_d     = lane_q;
    elem_d     = elem_q;
    wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d      = ovf_q | (in_v & ~wr);

    case ({wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    free_slots = 32'(DEPTH) - 32'(level_d);
    afull_d    = (free_slots <= 32'(AFULL_MARGIN));

    if (accept) begin
      lane_d = last_grp ? '0 : lane_q + LNW'(1);
      elem_d = (elem_q == LAST_ELEM) ? '0 : elem_q + EL_STEP;
      if (last_grp) begin
        state_d = EMPTY;
      end
    end
    if (pop) begin
      state_d = SEND;
      hold_d  = mem_q[rd_ptr_q];
      lane_d  = '0;
    end

    // Element 0 sits in the most significant slot, so group 0 is the top slice.
    shamt      = (NG - 1 - int'(lane_d)) * GW;
    out_d      = GW'(hold_d >> shamt);
    out_last_d = (state_d == SEND) && (elem_d == LAST_ELEM);
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      hold_q     <= '0;
      lane_q     <= '0;
      elem_q     <= '0;
      out_q      <= '0;
      out_last_q <= 1'b0;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      lane_q     <= lane_d;
      elem_q     <= elem_d;
      out_q      <= out_d;
      out_last_q <= out_last_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign out_v    = (state_q == SEND);
  assign out      = out_q;
  assign out_last = out_last_q;
  assign afull    = afull_q;
  assign ovf      = ovf_q;
  assign level    = level_q;

`ifdef MVAU_OUT_STREAM_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] vec_cnt_q, vec_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q + {31'd0, accept};
    vec_cnt_d  = vec_cnt_q + {31'd0, accept & out_last_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      vec_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign vec_cnt  = vec_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mvau_out_stream.sv
// Scoreboard bench for mvau_out_stream: stimulus pushes expected beats,
// a monitor pops and compares every accepted beat.
`default_nettype none
`timescale 1ns/1ps

module tb_mvau_out_stream;

  localparam int DEPTH  = 16;
  localparam int MH     = 8;
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_v, out_rdy, afull, out_v, out_last, ovf;
  logic [31:0] in_w;
  logic [15:0] out_w;
  logic [4:0]  level;

  logic        in_v_b, out_rdy_b, afull_b, out_v_b, out_last_b, ovf_b;
  logic [31:0] in_b, out_b;
  logic [4:0]  level_b;
`ifdef MVAU_OUT_STREAM_CNT_EN
  logic [31:0] bc_a, vc_a, bc_b, vc_b;
`endif

  mvau_out_stream #(.PE(2), .TDstI(16), .OUT_LANES(1), .MatrixH(MH),
                    .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in(in_w), .afull(afull),
    .out_v(out_v), .out_rdy(out_rdy), .out(out_w), .out_last(out_last),
    .ovf(ovf), .level(level)
`ifdef MVAU_OUT_STREAM_CNT_EN
    , .beat_cnt(bc_a), .vec_cnt(vc_a)
`endif
  );

  mvau_out_stream #(.PE(2), .TDstI(16), .OUT_LANES(2), .MatrixH(4),
                    .DEPTH(16), .AFULL_MARGIN(4)) dut_b (
    .clk(clk), .rst(rst), .in_v(in_v_b), .in(in_b), .afull(afull_b),
    .out_v(out_v_b), .out_rdy(out_rdy_b), .out(out_b), .out_last(out_last_b),
    .ovf(ovf_b), .level(level_b)
`ifdef MVAU_OUT_STREAM_CNT_EN
    , .beat_cnt(bc_b), .vec_cnt(vc_b)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          m_elem;
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] b_d[$];
  logic        b_l[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_chk++;
    $display("FAIL %s: bound expired, got no event required event", name);
  endtask

  // Reference: every accepted word yields its elements in order 0 first; the
  // last flag marks each MH-th element counted since reset.
  task automatic push_word(input logic [31:0] w);
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      b.d    = w[(1-k)*16 +: 16];
      b.l    = (m_elem == MH - 1);
      m_elem = (m_elem + 1) % MH;
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit keep);
    in_v = 1'b1;
    in_w = w;
    if (keep) push_word(w);
    step();
    in_v = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (!(level == 0 && !out_v && exp_q.size() == 0) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) fail_bound(name);
  endtask

  // Monitor: accepted beats against the scoreboard, plus hold stability.
  initial begin
    bit          ph;
    logic [15:0] po;
    logic        pl;
    beat_t       e;
    ph = 1'b0;
    po = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (ph) begin
        chk("hold_valid", out_v, 1);
        chk("hold_data", out_w, po);
        chk("hold_last", out_last, pl);
      end
      ph = !rst && out_v && !out_rdy;
      po = out_w;
      pl = out_last;
      if (!rst && out_v && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL beat_unexpected: got %0h required no beat", out_w);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_w, e.d);
          chk("beat_last", out_last, e.l);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_v_b && out_rdy_b) begin
        b_d.push_back(out_b);
        b_l.push_back(out_last_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit required completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          n, sent, c;
    rst = 1'b1; in_v = 1'b0; in_w = '0; out_rdy = 1'b0;
    in_v_b = 1'b0; in_b = '0; out_rdy_b = 1'b1; m_elem = 0;
    step();
    step();
    rst = 1'b0;

    chk("rst_out_v", out_v, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);
    chk("rst_out", out_w, 0);

    in_v_b = 1'b1; in_b = 32'h000A_000B; step();
    in_b = 32'h000C_000D; step();
    in_v_b = 1'b0;

    // Basic ordering and first-beat latency
    out_rdy = 1'b1;
    send(32'h0001_0002, 1);
    chk("lat_out_v_n", out_v, 0);
    chk("lat_level_n", level, 1);
    send(32'h0003_0004, 1);
    chk("lat_out_v_n1", out_v, 1);
    send(32'h0005_0006, 1);
    send(32'h0007_0008, 1);
    wait_idle("drain_basic", 100);

    chk("b_count", b_d.size(), 2);
    if (b_d.size() == 2) begin
      chk("b_beat0", b_d[0], 32'h000A_000B);
      chk("b_last0", b_l[0], 0);
      chk("b_beat1", b_d[1], 32'h000C_000D);
      chk("b_last1", b_l[1], 1);
    end
`ifdef MVAU_OUT_STREAM_CNT_EN
    chk("b_beat_cnt", bc_b, 2);
    chk("b_vec_cnt", vc_b, 1);
    chk("a_beat_cnt", bc_a, 8);
    chk("a_vec_cnt", vc_a, 1);
`endif

    // Backpressure with 0x0003 on the output
    out_rdy = 1'b0;
    send(32'h0001_0002, 1);
    send(32'h0003_0004, 1);
    send(32'h0005_0006, 1);
    send(32'h0007_0008, 1);
    out_rdy = 1'b1;
    c = 0;
    while (!(out_v && out_w == 16'h0003) && c < 20) begin
      step();
      c++;
    end
    if (c >= 20) fail_bound("bp_find_3");
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out", out_w, 16'h0003);
      chk("bp_out_v", out_v, 1);
    end
    out_rdy = 1'b1;
    wait_idle("drain_bp", 100);

    // Randomized rounds; at most DEPTH words from empty cannot overflow
    for (int r = 0; r < 8; r++) begin
      wait_idle("idle_rand", 200);
      n = $urandom_range(1, DEPTH);
      sent = 0;
      while (sent < n) begin
        out_rdy = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 1) == 1) begin
          w = $urandom;
          in_v = 1'b1;
          in_w = w;
          push_word(w);
          sent++;
        end else begin
          in_v = 1'b0;
        end
        step();
      end
      in_v = 1'b0;
      out_rdy = 1'b1;
      wait_idle("drain_rand", 400);
      chk("rand_ovf", ovf, 0);
    end

    // Fill: one word parked in the hold register, then DEPTH writes
    out_rdy = 1'b0;
    send($urandom, 1);
    step(); step(); step();
    chk("pre_level", level, 0);
    chk("pre_out_v", out_v, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      send($urandom, 1);
      chk("fill_level", level, k);
      chk("fill_afull", afull, (DEPTH - k) <= MARGIN);
      chk("fill_ovf", ovf, 0);
    end

    // Write coinciding with the final lane leaving at full
    out_rdy = 1'b1;
    step();
    send($urandom, 1);
    out_rdy = 1'b0;
    chk("sim_level", level, DEPTH);
    chk("sim_ovf", ovf, 0);
    chk("sim_afull", afull, 1);

    // Write while full with no pop is dropped
    send($urandom, 0);
    chk("drop_level", level, DEPTH);
    chk("drop_ovf", ovf, 1);
    step(); step();
    chk("ovf_sticky", ovf, 1);
    out_rdy = 1'b1;
    wait_idle("drain_fill", 200);
    chk("drain_afull", afull, 0);
    chk("drain_level", level, 0);
    chk("drain_ovf", ovf, 1);

    // Reset mid-vector with five words queued
    out_rdy = 1'b0;
    for (int k = 0; k < 6; k++) send($urandom, 1);
    step();
    chk("mid_level", level, 5);
    out_rdy = 1'b1;
    step();
    rst = 1'b1;
    out_rdy = 1'b0;
    exp_q.delete();
    m_elem = 0;
    step();
    rst = 1'b0;
    chk("mrst_out_v", out_v, 0);
    chk("mrst_level", level, 0);
    chk("mrst_ovf", ovf, 0);
    chk("mrst_out", out_w, 0);
    out_rdy = 1'b1;
    step(); step();
    chk("mrst_quiet", out_v, 0);
    send(32'h0011_0012, 1);
    send(32'h0013_0014, 1);
    send(32'h0015_0016, 1);
    send(32'h0017_0018, 1);
    wait_idle("drain_mrst", 100);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
